// File: rtl/msg_arbiter.sv
// Two-level round-robin message arbiter. It offers one source's message to the frame
// encoder, routes read strobes to that source and aborts a message that stalls too long.
module msg_arbiter #(
  parameter int               N_REQ     = 8,
  parameter logic [N_REQ-1:0] PRIO_MASK = {{(N_REQ-1){1'b0}}, 1'b1},
  parameter int               STARVE    = 4,
  parameter int               TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_REQ-1:0]   src_mask,
  input  logic [N_REQ-1:0]   req_bus,
  input  logic [8*N_REQ-1:0] len_bus,
  output logic [N_REQ-1:0]   rdreq_bus,
  output logic               msg_valid,
  output logic [4:0]         msg_src,
  output logic [7:0]         msg_len,
  input  logic               msg_ready,
  input  logic               beat,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY, S_RELEASE} state_t;

  state_t         state;
  logic [PW-1:0]  src_q;
  logic [PW-1:0]  hi_ptr;
  logic [PW-1:0]  lo_ptr;
  logic [7:0]     beat_cnt;
  logic [IW-1:0]  idle_cnt;
  logic [SW-1:0]  starve_cnt;
  logic           grant_lo;
  logic           low_waiting;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] elig_hi;
  logic [N_REQ-1:0] elig_lo;
  logic [PW:0]      pick_hi;
  logic [PW:0]      pick_lo;
  logic             low_wins;
  logic [PW-1:0]    win_idx;
  logic [7:0]       len_arr [N_REQ];

  // Returns {found, index} of the first set bit at or after ptr, wrapping around.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] vec,
                                          input logic [PW-1:0]    ptr);
    logic [PW:0] res;
    int          pos;
    res = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      pos = int'(ptr) + off;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (vec[PW'(pos)]) res = {1'b1, PW'(pos)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  assign elig     = req_bus & ~src_mask;
  assign elig_hi  = elig & PRIO_MASK;
  assign elig_lo  = elig & ~PRIO_MASK;
  assign pick_hi  = rr_pick(elig_hi, hi_ptr);
  assign pick_lo  = rr_pick(elig_lo, lo_ptr);
  assign low_wins = pick_lo[PW] && (!pick_hi[PW] || starve_cnt >= SW'(STARVE));
  assign win_idx  = low_wins ? pick_lo[PW-1:0] : pick_hi[PW-1:0];
  assign msg_src  = 5'(src_q);

  always_comb begin
    for (int i = 0; i < N_REQ; i++) len_arr[i] = len_bus[8*i +: 8];
  end

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  // Only BUSY beats reach a source; the terminal beat already moved us to RELEASE,
  // so surplus beats fall on the floor. Reset gates the strobe in the same cycle.
  always_comb begin
    rdreq_bus = '0;
    if (!rst && state == S_BUSY && beat) rdreq_bus[src_q] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      src_q       <= '0;
      hi_ptr      <= '0;
      lo_ptr      <= '0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      starve_cnt  <= '0;
      grant_lo    <= 1'b0;
      low_waiting <= 1'b0;
      msg_valid   <= 1'b0;
      msg_len     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && (pick_hi[PW] || pick_lo[PW])) begin
            state       <= S_OFFER;
            msg_valid   <= 1'b1;
            busy        <= 1'b1;
            src_q       <= win_idx;
            msg_len     <= len_arr[win_idx];
            grant_lo    <= low_wins;
            low_waiting <= pick_lo[PW];
          end
        end
        S_OFFER: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            beat_cnt  <= '0;
            idle_cnt  <= '0;
            state     <= (msg_len == 8'd0) ? S_RELEASE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            idle_cnt <= '0;
            if (beat_cnt + 8'd1 == msg_len) state <= S_RELEASE;
          end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
          if (grant_lo) begin
            lo_ptr     <= next_ptr(src_q);
            starve_cnt <= '0;
          end else begin
            hi_ptr <= next_ptr(src_q);
            // Count high grants made while a low source was kept waiting; saturate at the limit.
            if (low_waiting && starve_cnt < SW'(STARVE)) starve_cnt <= starve_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_arbiter.sv
// Directed testbench for msg_arbiter: arbitration order, starvation relief, zero-length
// messages, stall abort, reset mid-message, enable and source masking.
module tb_msg_arbiter;

  localparam int N  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [N-1:0]   src_mask;
  logic [N-1:0]   req_bus;
  logic [8*N-1:0] len_bus;
  logic [N-1:0]   rdreq_bus;
  logic           msg_valid;
  logic [4:0]     msg_src;
  logic [7:0]     msg_len;
  logic           msg_ready;
  logic           beat;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  msg_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .src_mask(src_mask), .req_bus(req_bus),
    .len_bus(len_bus), .rdreq_bus(rdreq_bus), .msg_valid(msg_valid), .msg_src(msg_src),
    .msg_len(msg_len), .msg_ready(msg_ready), .beat(beat), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len_all(input logic [7:0] l);
    for (int i = 0; i < N; i++) len_bus[8*i +: 8] = l;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; src_mask = '0; req_bus = '0;
    msg_ready = 1'b0; beat = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (msg_valid !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    ok = (msg_valid === 1'b1);
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic accept();
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
  endtask

  task automatic do_beats(input int n, input logic [4:0] src, output int pulses, output int bad);
    logic [N-1:0] one_hot;
    one_hot = N'(1) << src;
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      #1;
      if (rdreq_bus !== '0) pulses++;
      if (rdreq_bus !== '0 && rdreq_bus !== one_hot) bad++;
      step();
    end
    beat = 1'b0;
  endtask

  task automatic serve(input int n, output logic [4:0] src, output int pulses,
                       output int bad, output bit ok);
    bit okv, oki;
    oki = 1'b0;
    pulses = 0;
    bad = 0;
    wait_valid(okv);
    src = msg_src;
    if (okv) begin
      accept();
      do_beats(n, src, pulses, bad);
      wait_idle(oki);
    end
    ok = okv && oki;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req_bus = 8'hFF; src_mask = '0; beat = 1'b1; msg_ready = 1'b1;
    set_len_all(8'd3);
    step();
    step();
    if ({msg_valid, busy, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {msg_valid, busy, timeout_err});
    end
    checks++;
    if (msg_src !== 5'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", msg_src); end
    checks++;
    if (msg_len !== 8'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", msg_len); end
    checks++;
    if (rdreq_bus !== 8'h00) begin errors++; $display("FAIL reset_rdreq: got %h expected 00", rdreq_bus); end
    checks++;
  endtask

  task automatic test_latency();
    logic [4:0] src;
    int pulses, bad;
    bit ok;
    apply_reset();
    set_len_all(8'd2);
    en = 1'b1;
    req_bus = 8'h24;
    step();
    if (msg_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL lat_valid: got valid=%b busy=%b expected 1 1", msg_valid, busy);
    end
    checks++;
    if (msg_src !== 5'd2 || msg_len !== 8'd2) begin
      errors++; $display("FAIL lat_grant: got src=%0d len=%0d expected 2 2", msg_src, msg_len);
    end
    checks++;
    req_bus = '0;
    repeat (3) step();
    if (msg_valid !== 1'b1 || msg_src !== 5'd2 || msg_len !== 8'd2) begin
      errors++; $display("FAIL offer_hold: got valid=%b src=%0d len=%0d expected 1 2 2",
                         msg_valid, msg_src, msg_len);
    end
    checks++;
    serve(2, src, pulses, bad, ok);
    if (!ok || pulses != 2 || bad != 0) begin
      errors++; $display("FAIL lat_serve: got ok=%0d pulses=%0d bad=%0d expected 1 2 0", ok, pulses, bad);
    end
    checks++;
  endtask

  task automatic test_round_robin();
    int exp_src [4] = '{2, 5, 2, 5};
    logic [4:0] src;
    int pulses, bad;
    bit ok;
    apply_reset();
    set_len_all(8'd2);
    en = 1'b1;
    req_bus = 8'h24;
    for (int k = 0; k < 4; k++) begin
      serve(3, src, pulses, bad, ok);
      if (!ok || src !== 5'(exp_src[k])) begin
        errors++; $display("FAIL rr_src[%0d]: got src=%0d ok=%0d expected %0d", k, src, ok, exp_src[k]);
      end
      checks++;
      if (pulses != 2 || bad != 0) begin
        errors++; $display("FAIL rr_rdreq[%0d]: got pulses=%0d bad=%0d expected 2 0", k, pulses, bad);
      end
      checks++;
    end
  endtask

  task automatic test_priority();
    int exp_src [10] = '{0, 0, 0, 0, 3, 0, 0, 0, 0, 3};
    logic [4:0] src;
    int pulses, bad;
    bit ok;
    apply_reset();
    set_len_all(8'd1);
    en = 1'b1;
    req_bus = 8'h09;
    for (int k = 0; k < 10; k++) begin
      serve(1, src, pulses, bad, ok);
      if (!ok || src !== 5'(exp_src[k]) || pulses != 1 || bad != 0) begin
        errors++; $display("FAIL prio[%0d]: got src=%0d pulses=%0d ok=%0d expected %0d 1 1",
                           k, src, pulses, ok, exp_src[k]);
      end
      checks++;
    end
  endtask

  task automatic test_zero_len();
    apply_reset();
    set_len_all(8'd4);
    len_bus[15:8] = 8'd0;
    en = 1'b1;
    req_bus = 8'h02;
    step();
    if (msg_valid !== 1'b1 || msg_src !== 5'd1 || msg_len !== 8'd0) begin
      errors++; $display("FAIL zl_offer: got valid=%b src=%0d len=%0d expected 1 1 0",
                         msg_valid, msg_src, msg_len);
    end
    checks++;
    req_bus = '0;
    msg_ready = 1'b1;
    beat = 1'b1;
    #1;
    if (rdreq_bus !== 8'h00) begin errors++; $display("FAIL zl_offer_rdreq: got %h expected 00", rdreq_bus); end
    checks++;
    step();
    msg_ready = 1'b0;
    if (msg_valid !== 1'b0 || busy !== 1'b1 || rdreq_bus !== 8'h00) begin
      errors++; $display("FAIL zl_release: got valid=%b busy=%b rdreq=%h expected 0 1 00",
                         msg_valid, busy, rdreq_bus);
    end
    checks++;
    step();
    if (busy !== 1'b0 || rdreq_bus !== 8'h00) begin
      errors++; $display("FAIL zl_idle: got busy=%b rdreq=%h expected 0 00", busy, rdreq_bus);
    end
    checks++;
    beat = 1'b0;
  endtask

  task automatic test_timeout();
    int pulses, bad, n;
    apply_reset();
    set_len_all(8'd3);
    len_bus[55:48] = 8'd5;
    en = 1'b1;
    req_bus = 8'h40;
    step();
    if (msg_valid !== 1'b1 || msg_src !== 5'd6 || msg_len !== 8'd5) begin
      errors++; $display("FAIL to_grant: got valid=%b src=%0d len=%0d expected 1 6 5",
                         msg_valid, msg_src, msg_len);
    end
    checks++;
    req_bus = 8'h42;
    accept();
    do_beats(2, 5'd6, pulses, bad);
    if (pulses != 2 || bad != 0) begin
      errors++; $display("FAIL to_beats: got pulses=%0d bad=%0d expected 2 0", pulses, bad);
    end
    checks++;
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n != TO || busy !== 1'b1) begin
      errors++; $display("FAIL to_delay: got %0d cycles busy=%b expected %0d 1", n, busy, TO);
    end
    checks++;
    step();
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL to_pulse: got err=%b busy=%b expected 0 0", timeout_err, busy);
    end
    checks++;
    step();
    if (msg_valid !== 1'b1 || msg_src !== 5'd1) begin
      errors++; $display("FAIL to_next: got valid=%b src=%0d expected 1 1", msg_valid, msg_src);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] src;
    int pulses, bad;
    bit ok;
    apply_reset();
    set_len_all(8'd5);
    en = 1'b1;
    req_bus = 8'h24;
    serve(5, src, pulses, bad, ok);
    if (!ok || src !== 5'd2 || pulses != 5) begin
      errors++; $display("FAIL rm_first: got src=%0d pulses=%0d ok=%0d expected 2 5 1", src, pulses, ok);
    end
    checks++;
    wait_valid(ok);
    if (!ok || msg_src !== 5'd5) begin
      errors++; $display("FAIL rm_second: got src=%0d ok=%0d expected 5 1", msg_src, ok);
    end
    checks++;
    accept();
    do_beats(3, 5'd5, pulses, bad);
    rst = 1'b1;
    beat = 1'b1;
    #1;
    if (rdreq_bus !== 8'h00) begin errors++; $display("FAIL rm_rst_rdreq: got %h expected 00", rdreq_bus); end
    checks++;
    step();
    if ({msg_valid, busy, timeout_err, msg_src, msg_len, rdreq_bus} !== '0) begin
      errors++; $display("FAIL rm_outputs: got valid=%b busy=%b err=%b src=%0d len=%0d rdreq=%h expected all 0",
                         msg_valid, busy, timeout_err, msg_src, msg_len, rdreq_bus);
    end
    checks++;
    rst = 1'b0;
    #1;
    if (rdreq_bus !== 8'h00) begin errors++; $display("FAIL rm_idle_rdreq: got %h expected 00", rdreq_bus); end
    checks++;
    step();
    if (msg_valid !== 1'b1 || msg_src !== 5'd2 || rdreq_bus !== 8'h00) begin
      errors++; $display("FAIL rm_ptr: got valid=%b src=%0d rdreq=%h expected 1 2 00",
                         msg_valid, msg_src, rdreq_bus);
    end
    checks++;
    beat = 1'b0;
  endtask

  task automatic test_enable_mask();
    logic [4:0] src;
    int pulses, bad, vcnt;
    bit ok;
    apply_reset();
    set_len_all(8'd2);
    en = 1'b1;
    req_bus = 8'h24;
    wait_valid(ok);
    en = 1'b0;
    accept();
    do_beats(2, 5'd2, pulses, bad);
    if (!ok || pulses != 2 || bad != 0) begin
      errors++; $display("FAIL en_complete: got ok=%0d pulses=%0d bad=%0d expected 1 2 0", ok, pulses, bad);
    end
    checks++;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (msg_valid !== 1'b0) vcnt++;
    end
    if (vcnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL en_hold: got %0d valid cycles busy=%b expected 0 0", vcnt, busy);
    end
    checks++;
    en = 1'b1;
    src_mask = 8'h04;
    for (int k = 0; k < 3; k++) begin
      serve(2, src, pulses, bad, ok);
      if (!ok || src !== 5'd5 || pulses != 2) begin
        errors++; $display("FAIL mask[%0d]: got src=%0d pulses=%0d ok=%0d expected 5 2 1", k, src, pulses, ok);
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; src_mask = '0; req_bus = '0; len_bus = '0;
    msg_ready = 1'b0; beat = 1'b0;
    test_reset();
    test_latency();
    test_round_robin();
    test_priority();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_enable_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
